// File: rtl/bp_fe_mem_sched.sv
// bp_fe_mem_sched: command scheduler in front of bp_fe_mem.
// Arbitrates ITLB fence, ITLB fill, fence.i and instruction fetches onto the
// single mem_cmd port, tracks the two fetches in flight, poisons stage 1 on
// redirects/misses and replays a missing fetch so the PC generator only sees
// final hits and faults.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   tlb_fence_v_i             ITLB fence request
//   fill_v_i/vtag/entry       ITLB fill request and payload
//   icache_fence_v_i          fence.i request
//   fence_yumi_o              fence or fill issued this cycle
//   fetch_vaddr_i/fetch_v_i   fetch request, fetch_ready_o accepts it (comb)
//   redirect_v_i              kill every fetch in flight
//   mem_cmd_o/v_o/yumi_i      command to bp_fe_mem {op, vaddr, vtag, entry}
//   mem_poison_o              poison the stage-1 fetch
//   mem_resp_i/v_i            response {data, itlb_miss, icache_miss, af, pf}
//   cache_req_complete_i      icache miss service done
//   fetch_resp_o/v_o          final response {vaddr, data, af, pf}
module bp_fe_mem_sched
  #(parameter int unsigned vaddr_width_p = 39
   ,parameter int unsigned vtag_width_p  = 27
   ,parameter int unsigned ptag_width_p  = 28
   ,parameter int unsigned instr_width_p = 32
   ,localparam int unsigned tlb_entry_width_lp  = ptag_width_p + 4
   ,localparam int unsigned mem_cmd_width_lp    = 2 + vaddr_width_p + vtag_width_p + tlb_entry_width_lp
   ,localparam int unsigned mem_resp_width_lp   = instr_width_p + 4
   ,localparam int unsigned fetch_resp_width_lp = vaddr_width_p + instr_width_p + 2)
  (input  logic                           clk_i
   ,input  logic                          reset_i
   ,input  logic                          tlb_fence_v_i
   ,input  logic                          fill_v_i
   ,input  logic [vtag_width_p-1:0]       fill_vtag_i
   ,input  logic [tlb_entry_width_lp-1:0] fill_entry_i
   ,input  logic                          icache_fence_v_i
   ,output logic                          fence_yumi_o
   ,input  logic [vaddr_width_p-1:0]      fetch_vaddr_i
   ,input  logic                          fetch_v_i
   ,output logic                          fetch_ready_o
   ,input  logic                          redirect_v_i
   ,output logic [mem_cmd_width_lp-1:0]   mem_cmd_o
   ,output logic                          mem_cmd_v_o
   ,input  logic                          mem_cmd_yumi_i
   ,output logic                          mem_poison_o
   ,input  logic [mem_resp_width_lp-1:0]  mem_resp_i
   ,input  logic                          mem_resp_v_i
   ,input  logic                          cache_req_complete_i
   ,output logic [fetch_resp_width_lp-1:0] fetch_resp_o
   ,output logic                          fetch_resp_v_o
   );

   localparam logic [1:0] op_fetch_lp        = 2'd0;
   localparam logic [1:0] op_fill_lp         = 2'd1;
   localparam logic [1:0] op_itlb_fence_lp   = 2'd2;
   localparam logic [1:0] op_icache_fence_lp = 2'd3;

   typedef enum logic [1:0] {e_run, e_wait_fill, e_wait_miss, e_replay} state_e;

   state_e                     state_r, state_n;
   logic                       s1_v_r, s2_v_r;
   logic [vaddr_width_p-1:0]   s1_vaddr_r, s2_vaddr_r;
   logic [vaddr_width_p-1:0]   replay_vaddr_r, replay_vaddr_n;

   logic                       run, higher_req, replay_req, new_fetch_ok, new_fetch_req;
   logic                       resp_miss, fetch_issue, replay_issue;
   logic [1:0]                 cmd_op;
   logic [vaddr_width_p-1:0]   cmd_vaddr;
   logic [vtag_width_p-1:0]    cmd_vtag;
   logic [tlb_entry_width_lp-1:0] cmd_entry;
   logic [instr_width_p-1:0]   resp_data;
   logic                       resp_itlb_miss, resp_icache_miss, resp_af, resp_pf;

   // Arbitration, poison, response pass-through and next state
   always_comb begin
      state_n        = state_r;
      replay_vaddr_n = replay_vaddr_r;
      mem_cmd_v_o    = 1'b0;
      mem_cmd_o      = '0;
      fence_yumi_o   = 1'b0;
      fetch_ready_o  = 1'b0;
      mem_poison_o   = 1'b0;
      fetch_resp_v_o = 1'b0;
      fetch_resp_o   = '0;
      fetch_issue    = 1'b0;
      replay_issue   = 1'b0;

      resp_data        = mem_resp_i[mem_resp_width_lp-1:4];
      resp_itlb_miss   = mem_resp_i[3];
      resp_icache_miss = mem_resp_i[2];
      resp_af          = mem_resp_i[1];
      resp_pf          = mem_resp_i[0];
      resp_miss        = mem_resp_v_i & (resp_itlb_miss | resp_icache_miss);

      run           = (state_r == e_run);
      higher_req    = tlb_fence_v_i | fill_v_i | icache_fence_v_i;
      replay_req    = (state_r == e_replay) & ~redirect_v_i;
      // A miss holds new fetches back unless a redirect already restarts the stream
      new_fetch_ok  = run & ~(resp_miss & ~redirect_v_i);
      new_fetch_req = fetch_v_i & new_fetch_ok;

      cmd_op    = op_fetch_lp;
      cmd_vaddr = fetch_vaddr_i;
      cmd_vtag  = '0;
      cmd_entry = '0;
      if (tlb_fence_v_i) begin
         cmd_op    = op_itlb_fence_lp;
         cmd_vaddr = '0;
      end else if (fill_v_i) begin
         cmd_op    = op_fill_lp;
         cmd_vaddr = '0;
         cmd_vtag  = fill_vtag_i;
         cmd_entry = fill_entry_i;
      end else if (icache_fence_v_i) begin
         cmd_op    = op_icache_fence_lp;
         cmd_vaddr = '0;
      end else if (replay_req) begin
         cmd_vaddr = replay_vaddr_r;
      end

      if (!reset_i) begin
         mem_cmd_v_o    = higher_req | replay_req | new_fetch_req;
         mem_cmd_o      = {cmd_op, cmd_vaddr, cmd_vtag, cmd_entry};
         fence_yumi_o   = mem_cmd_yumi_i & higher_req;
         fetch_ready_o  = new_fetch_ok & ~higher_req & mem_cmd_yumi_i;
         mem_poison_o   = redirect_v_i | resp_miss;
         fetch_resp_v_o = run & mem_resp_v_i & s2_v_r & ~resp_miss & ~redirect_v_i;
         fetch_resp_o   = {s2_vaddr_r, resp_data, resp_af, resp_pf};
         fetch_issue    = fetch_ready_o & fetch_v_i;
         replay_issue   = replay_req & ~higher_req & mem_cmd_yumi_i;
      end

      unique case (state_r)
         e_run: begin
            if (mem_resp_v_i & ~redirect_v_i) begin
               if (resp_itlb_miss) begin
                  state_n        = e_wait_fill;
                  replay_vaddr_n = s2_vaddr_r;
               end else if (resp_icache_miss) begin
                  state_n        = e_wait_miss;
                  replay_vaddr_n = s2_vaddr_r;
               end
            end
         end
         e_wait_fill: if (fence_yumi_o & ~tlb_fence_v_i & fill_v_i) state_n = e_replay;
         e_wait_miss: if (cache_req_complete_i) state_n = e_replay;
         e_replay:    if (replay_issue) state_n = e_run;
         default:     state_n = e_run;
      endcase

      // Redirect abandons any pending replay
      if (redirect_v_i) state_n = e_run;
   end

   // State and in-flight fetch tracking
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r        <= e_run;
         replay_vaddr_r <= '0;
         s1_v_r         <= 1'b0;
         s1_vaddr_r     <= '0;
         s2_v_r         <= 1'b0;
         s2_vaddr_r     <= '0;
      end else begin
         state_r        <= state_n;
         replay_vaddr_r <= replay_vaddr_n;
         s2_v_r         <= s1_v_r & ~mem_poison_o;
         s2_vaddr_r     <= s1_vaddr_r;
         s1_v_r         <= fetch_issue | replay_issue;
         if (replay_issue)     s1_vaddr_r <= replay_vaddr_r;
         else if (fetch_issue) s1_vaddr_r <= fetch_vaddr_i;
      end
   end

endmodule

// File: tb/tb_bp_fe_mem_sched.sv
// Directed bench for bp_fe_mem_sched: per-cycle vector table plus a few
// hand-written multi-cycle sequences (replay latency, redirect while waiting,
// reset from a wait state).
module tb_bp_fe_mem_sched;

   localparam int unsigned VA = 39;
   localparam int unsigned VT = 27;
   localparam int unsigned EN = 32;
   localparam int unsigned IW = 32;
   localparam int unsigned CW = 2 + VA + VT + EN;
   localparam int unsigned RW = IW + 4;
   localparam int unsigned FW = VA + IW + 2;

   localparam logic [VT-1:0] FILL_VTAG  = 27'h1234567;
   localparam logic [EN-1:0] FILL_ENTRY = 32'hABCD_0005;

   logic clk_i, reset_i;
   logic tlb_fence_v_i, fill_v_i, icache_fence_v_i, fence_yumi_o;
   logic [VA-1:0] fetch_vaddr_i;
   logic fetch_v_i, fetch_ready_o, redirect_v_i;
   logic [CW-1:0] mem_cmd_o;
   logic mem_cmd_v_o, mem_cmd_yumi_i, mem_poison_o;
   logic [RW-1:0] mem_resp_i;
   logic mem_resp_v_i, cache_req_complete_i;
   logic [FW-1:0] fetch_resp_o;
   logic fetch_resp_v_o;

   bp_fe_mem_sched dut
     (.clk_i(clk_i), .reset_i(reset_i)
      ,.tlb_fence_v_i(tlb_fence_v_i), .fill_v_i(fill_v_i)
      ,.fill_vtag_i(FILL_VTAG), .fill_entry_i(FILL_ENTRY)
      ,.icache_fence_v_i(icache_fence_v_i), .fence_yumi_o(fence_yumi_o)
      ,.fetch_vaddr_i(fetch_vaddr_i), .fetch_v_i(fetch_v_i), .fetch_ready_o(fetch_ready_o)
      ,.redirect_v_i(redirect_v_i)
      ,.mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i)
      ,.mem_poison_o(mem_poison_o)
      ,.mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i)
      ,.cache_req_complete_i(cache_req_complete_i)
      ,.fetch_resp_o(fetch_resp_o), .fetch_resp_v_o(fetch_resp_v_o));

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic tf, fl, icf, fv; logic [VA-1:0] va;
      logic rd, ym, rv; logic [3:0] rb; logic crc;
      logic cv; logic [1:0] op; logic [VA-1:0] cva;
      logic fy, fr, po, ov; logic [VA-1:0] ova; logic [1:0] ef;
   } vec_t;

   vec_t vecs[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] exp_cmd(input logic [1:0] op, input logic [VA-1:0] va);
      case (op)
         2'd0:    return {2'd0, va, 27'd0, 32'd0};
         2'd1:    return {2'd1, 39'd0, FILL_VTAG, FILL_ENTRY};
         default: return {op, 39'd0, 27'd0, 32'd0};
      endcase
   endfunction

   task automatic idle();
      tlb_fence_v_i = 0; fill_v_i = 0; icache_fence_v_i = 0;
      fetch_v_i = 0; fetch_vaddr_i = '0; redirect_v_i = 0;
      mem_cmd_yumi_i = 1; mem_resp_v_i = 0; mem_resp_i = '0;
      cache_req_complete_i = 0;
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
      idle();
   endtask

   task automatic resp(input logic [3:0] rb, input logic [IW-1:0] data);
      mem_resp_v_i = 1;
      mem_resp_i   = {data, rb};
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, ".cmd_v"}, mem_cmd_v_o, 0);
      chk({nm, ".cmd"}, mem_cmd_o, 0);
      chk({nm, ".fence_yumi"}, fence_yumi_o, 0);
      chk({nm, ".fetch_ready"}, fetch_ready_o, 0);
      chk({nm, ".poison"}, mem_poison_o, 0);
      chk({nm, ".resp_v"}, fetch_resp_v_o, 0);
   endtask

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int found;
      logic [IW-1:0] d;
      vec_t v;

      // tf fl icf fv va           rd ym rv rb      crc | cv op cva          fy fr po ov ova          ef
      vecs.push_back(vec_t'{0,0,0,1,'h80000000, 0,1,0,0,0,      1,0,'h80000000, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80000004, 0,1,0,0,0,      1,0,'h80000004, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80000008, 0,1,1,0,0,      1,0,'h80000008, 0,1,0,1,'h80000000,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,1,0,0,      0,0,0,          0,1,0,1,'h80000004,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,1,0,0,      0,0,0,          0,1,0,1,'h80000008,0});
      // icache miss on 0x40 with 0x44 in s1, replay after completion
      vecs.push_back(vec_t'{0,0,0,1,'h80000040, 0,1,0,0,0,      1,0,'h80000040, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80000044, 0,1,0,0,0,      1,0,'h80000044, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80000048, 0,1,1,'b0100,0, 0,0,0,          0,0,1,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80000048, 0,1,0,0,0,      0,0,0,          0,0,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80000048, 0,1,0,0,1,      0,0,0,          0,0,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80000048, 0,1,0,0,0,      1,0,'h80000040, 0,0,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,1,0,0,      0,0,0,          0,1,0,1,'h80000040,0});
      // ITLB miss on 0x1000, fence while waiting, fill, replay
      vecs.push_back(vec_t'{0,0,0,1,'h80001000, 0,1,0,0,0,      1,0,'h80001000, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,1,'b1000,0, 0,0,0,          0,0,1,0,0,0});
      vecs.push_back(vec_t'{1,0,0,0,0,          0,1,0,0,0,      1,2,0,          1,0,0,0,0,0});
      vecs.push_back(vec_t'{0,1,0,0,0,          0,1,0,0,0,      1,1,0,          1,0,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      1,0,'h80001000, 0,0,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,1,0,0,      0,0,0,          0,1,0,1,'h80001000,0});
      // all four requesters at once, each dropping after it is served
      vecs.push_back(vec_t'{1,1,1,1,'h80003000, 0,1,0,0,0,      1,2,0,          1,0,0,0,0,0});
      vecs.push_back(vec_t'{0,1,1,1,'h80003000, 0,1,0,0,0,      1,1,0,          1,0,0,0,0,0});
      vecs.push_back(vec_t'{0,0,1,1,'h80003000, 0,1,0,0,0,      1,3,0,          1,0,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80003000, 0,1,0,0,0,      1,0,'h80003000, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,1,0,0,      0,0,0,          0,1,0,1,'h80003000,0});
      // redirect together with a miss response, new fetch 0x2000 accepted
      vecs.push_back(vec_t'{0,0,0,1,'h80005000, 0,1,0,0,0,      1,0,'h80005000, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80002000, 1,1,1,'b0100,0, 1,0,'h80002000, 0,1,1,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,1,0,0,      0,0,0,          0,1,0,1,'h80002000,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      // page fault passes through, stray cache_req_complete ignored
      vecs.push_back(vec_t'{0,0,0,1,'h80006000, 0,1,0,0,0,      1,0,'h80006000, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,1,'b0001,0, 0,0,0,          0,1,0,1,'h80006000,'b01});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,1,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      // no yumi blocks the fetch; redirect suppresses a hit
      vecs.push_back(vec_t'{0,0,0,1,'h80007000, 0,0,0,0,0,      1,0,'h80007000, 0,0,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,1,'h80007000, 0,1,0,0,0,      1,0,'h80007000, 0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          1,1,1,0,0,      0,0,0,          0,1,1,0,0,0});
      vecs.push_back(vec_t'{0,0,0,0,0,          0,1,0,0,0,      0,0,0,          0,1,0,0,0,0});

      // Reset with every requester active: outputs must stay low
      idle();
      reset_i = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #1;
         tlb_fence_v_i = 1; fill_v_i = 1; fetch_v_i = 1; fetch_vaddr_i = 39'h80000000;
         redirect_v_i = 1; resp(4'b0100, 32'h1); #3;
         chk_quiet($sformatf("reset%0d", i));
      end
      cyc();
      reset_i = 0;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         d = 32'hD000_0000 | 32'(i);
         @(posedge clk_i);
         #1;
         tlb_fence_v_i = v.tf; fill_v_i = v.fl; icache_fence_v_i = v.icf;
         fetch_v_i = v.fv; fetch_vaddr_i = v.va; redirect_v_i = v.rd;
         mem_cmd_yumi_i = v.ym; mem_resp_v_i = v.rv; mem_resp_i = {d, v.rb};
         cache_req_complete_i = v.crc;
         #3;
         chk($sformatf("v%0d.cmd_v", i), mem_cmd_v_o, v.cv);
         chk($sformatf("v%0d.fence_yumi", i), fence_yumi_o, v.fy);
         chk($sformatf("v%0d.fetch_ready", i), fetch_ready_o, v.fr);
         chk($sformatf("v%0d.poison", i), mem_poison_o, v.po);
         chk($sformatf("v%0d.resp_v", i), fetch_resp_v_o, v.ov);
         if (v.cv) chk($sformatf("v%0d.cmd", i), mem_cmd_o, exp_cmd(v.op, v.cva));
         if (v.ov) chk($sformatf("v%0d.resp", i), fetch_resp_o, {v.ova, d, v.ef});
      end

      // Replay comes exactly one cycle after cache_req_complete
      cyc(); fetch_v_i = 1; fetch_vaddr_i = 39'h80009000; #3;
      chk("h1.issue", fetch_ready_o, 1);
      cyc(); #3;
      cyc(); resp(4'b0100, 32'h0); #3;
      chk("h1.poison", mem_poison_o, 1);
      chk("h1.resp_v", fetch_resp_v_o, 0);
      cyc(); cache_req_complete_i = 1; #3;
      chk("h1.wait_cmd_v", mem_cmd_v_o, 0);
      found = 0;
      for (int k = 1; k <= 4 && found == 0; k++) begin
         cyc(); #3;
         if (mem_cmd_v_o) found = k;
      end
      chk("h1.replay_lat", 32'(found), 1);
      chk("h1.replay_cmd", mem_cmd_o, exp_cmd(2'd0, 39'h80009000));
      cyc(); #3;
      cyc(); resp(4'b0000, 32'h1111_2222); #3;
      chk("h1.resp_v2", fetch_resp_v_o, 1);
      chk("h1.resp", fetch_resp_o, {39'h80009000, 32'h1111_2222, 2'b00});

      // Redirect while waiting on an icache miss drops the replay
      cyc(); fetch_v_i = 1; fetch_vaddr_i = 39'h8000A000; #3;
      cyc(); #3;
      cyc(); resp(4'b0100, 32'h0); #3;
      chk("h2.poison", mem_poison_o, 1);
      cyc(); #3;
      chk("h2.wait_ready", fetch_ready_o, 0);
      cyc(); redirect_v_i = 1; #3;
      chk("h2.redir_poison", mem_poison_o, 1);
      cyc(); #3;
      chk("h2.run_ready", fetch_ready_o, 1);
      cyc(); cache_req_complete_i = 1; #3;
      cyc(); #3;
      chk("h2.no_replay", mem_cmd_v_o, 0);
      chk("h2.ready", fetch_ready_o, 1);

      // Reset out of e_wait_fill returns to e_run
      cyc(); fetch_v_i = 1; fetch_vaddr_i = 39'h8000B000; #3;
      cyc(); #3;
      cyc(); resp(4'b1000, 32'h0); #3;
      chk("h3.poison", mem_poison_o, 1);
      cyc(); #3;
      chk("h3.wait_ready", fetch_ready_o, 0);
      cyc(); reset_i = 1; fetch_v_i = 1; fill_v_i = 1; #3;
      chk_quiet("h3.reset");
      cyc(); reset_i = 0; #3;
      chk("h3.ready", fetch_ready_o, 1);
      chk("h3.cmd_v", mem_cmd_v_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
